// File: rtl/proc_mem_pkg.sv
// Shared request-type encodings, response payload layout and sizing helpers
// for the pipelined processor memory.
package proc_mem_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic              typ;
    logic [WORD_W-1:0] data;
  } dmem_resp_t;

  function automatic int unsigned word_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/proc_mem_port_q.sv
// Per-port response path: fixed-latency valid/data pipeline feeding an
// in-order response FIFO, with an outstanding counter that throttles req_rdy.
module proc_mem_port_q #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned QDEPTH  = 2,
  parameter int unsigned W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_acc,
  input  logic [W-1:0] i_acc_data,
  input  logic         i_resp_rdy,
  output logic         o_req_rdy,
  output logic         o_resp_val,
  output logic [W-1:0] o_resp_data
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [LATENCY-1:0] r_pipe_val;
  logic [W-1:0]       r_pipe_data [LATENCY];
  logic [W-1:0]       r_fifo [QDEPTH];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_fifo_cnt, r_out_cnt;
  logic               r_req_rdy;

  logic          w_tail_val, w_fifo_empty, w_resp_val, w_resp_fire;
  logic          w_push, w_pop;
  logic [CW-1:0] w_fifo_cnt_next, w_out_cnt_next;
  logic [W-1:0]  w_resp_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Tail of the pipe bypasses the FIFO only when nothing older is queued.
  assign w_tail_val   = r_pipe_val[LATENCY-1];
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_resp_val   = !w_fifo_empty || w_tail_val;
  assign w_resp_fire  = w_resp_val && i_resp_rdy;
  assign w_push       = w_tail_val && !(w_fifo_empty && i_resp_rdy);
  assign w_pop        = !w_fifo_empty && i_resp_rdy;
  assign w_resp_data  = w_fifo_empty ? r_pipe_data[LATENCY-1] : r_fifo[r_rd_ptr];

  assign o_resp_val  = w_resp_val;
  assign o_resp_data = w_resp_val ? w_resp_data : '0;
  assign o_req_rdy   = r_req_rdy;

  always_comb begin
    w_out_cnt_next  = r_out_cnt;
    w_fifo_cnt_next = r_fifo_cnt;
    if (i_acc && !w_resp_fire)      w_out_cnt_next = r_out_cnt + CW'(1);
    else if (!i_acc && w_resp_fire) w_out_cnt_next = r_out_cnt - CW'(1);
    if (w_push && !w_pop)           w_fifo_cnt_next = r_fifo_cnt + CW'(1);
    else if (!w_push && w_pop)      w_fifo_cnt_next = r_fifo_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_val <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_out_cnt  <= '0;
      r_req_rdy  <= 1'b1;
    end else begin
      r_pipe_val[0] <= i_acc;
      for (int i = 1; i < LATENCY; i++) r_pipe_val[i] <= r_pipe_val[i-1];
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_fifo_cnt <= w_fifo_cnt_next;
      r_out_cnt  <= w_out_cnt_next;
      r_req_rdy  <= (w_out_cnt_next < CW'(QDEPTH));
    end
  end

  // Payload storage needs no reset: validity is tracked separately above.
  always_ff @(posedge clk) begin
    r_pipe_data[0] <= i_acc_data;
    for (int i = 1; i < LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
    if (w_push) r_fifo[r_wr_ptr] <= r_pipe_data[LATENCY-1];
  end

endmodule

// File: rtl/proc_mem_pipe.sv
// Dual-port (instruction + data) word memory with val/rdy handshakes, fixed
// read latency, byte-masked writes and per-port in-order response buffering.
module proc_mem_pipe
  import proc_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  input  logic [3:0]  dmemreq_strb,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  output logic        dmemresp_type,
  output logic [31:0] dmemresp_rdata
);

  localparam int unsigned IW = word_idx_w(DEPTH);
  localparam int unsigned DW = $bits(dmem_resp_t);

  logic [WORD_W-1:0] r_mem [DEPTH];

  logic [IW-1:0] w_iidx, w_didx;
  logic          w_iacc, w_dacc, w_dwrite;
  dmem_resp_t    w_dreq_pay, w_dresp;
  logic [DW-1:0] w_dresp_bits;
  logic          w_unused_addr;

  assign w_iidx   = imemreq_addr[IW+1:2];
  assign w_didx   = dmemreq_addr[IW+1:2];
  assign w_iacc   = imemreq_val && imemreq_rdy && !rst;
  assign w_dacc   = dmemreq_val && dmemreq_rdy && !rst;
  assign w_dwrite = w_dacc && (dmemreq_type == MEMREQ_WRITE);

  // Upper address bits alias and byte-offset bits are ignored.
  assign w_unused_addr = ^{imemreq_addr[31:IW+2], imemreq_addr[1:0],
                           dmemreq_addr[31:IW+2], dmemreq_addr[1:0]};

  // Array is never reset so preloaded program contents survive rst.
  always_ff @(posedge clk) begin
    if (w_dwrite) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (dmemreq_strb[b]) r_mem[w_didx][8*b +: 8] <= dmemreq_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_dreq_pay.typ  = dmemreq_type;
    w_dreq_pay.data = (dmemreq_type == MEMREQ_WRITE) ? '0 : r_mem[w_didx];
  end

  proc_mem_port_q #(.LATENCY(LATENCY), .QDEPTH(QDEPTH), .W(WORD_W)) u_iport (
    .clk         (clk),
    .rst         (rst),
    .i_acc       (w_iacc),
    .i_acc_data  (r_mem[w_iidx]),
    .i_resp_rdy  (imemresp_rdy),
    .o_req_rdy   (imemreq_rdy),
    .o_resp_val  (imemresp_val),
    .o_resp_data (imemresp_data)
  );

  proc_mem_port_q #(.LATENCY(LATENCY), .QDEPTH(QDEPTH), .W(DW)) u_dport (
    .clk         (clk),
    .rst         (rst),
    .i_acc       (w_dacc),
    .i_acc_data  (w_dreq_pay),
    .i_resp_rdy  (dmemresp_rdy),
    .o_req_rdy   (dmemreq_rdy),
    .o_resp_val  (dmemresp_val),
    .o_resp_data (w_dresp_bits)
  );

  assign w_dresp        = dmem_resp_t'(w_dresp_bits);
  assign dmemresp_type  = w_dresp.typ;
  assign dmemresp_rdata = w_dresp.data;

endmodule

// File: tb/tb_proc_mem_pipe.sv
// Self-checking bench for proc_mem_pipe: directed scenarios plus a randomized
// run checked cycle-by-cycle against a queue-based reference model.
module tb_proc_mem_pipe;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;
  localparam int QD    = 4;
  localparam int NRAND = 600;

  typedef struct {
    logic [31:0] data;
    logic        typ;
    int          cyc;
  } exp_t;

  logic        clk, rst;
  logic        imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic [31:0] imemreq_addr, imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;
  logic [3:0]  dmemreq_strb;
  logic        dmemresp_val, dmemresp_rdy, dmemresp_type;
  logic [31:0] dmemresp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  proc_mem_pipe #(.DEPTH(DEPTH), .LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata), .dmemreq_strb(dmemreq_strb),
    .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_type(dmemresp_type),
    .dmemresp_rdata(dmemresp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  // Single dmem transaction with nothing else outstanding on the port.
  task automatic dreq(input logic typ, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic ok, output logic rtyp,
                      output logic [31:0] rdata);
    int n;
    ok = 1'b1;
    dmemresp_rdy = 1'b1;
    dmemreq_val = 1'b1; dmemreq_type = typ; dmemreq_addr = a;
    dmemreq_wdata = d; dmemreq_strb = s;
    n = 0;
    while (dmemreq_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) ok = 1'b0;
    tick();
    dmemreq_val = 1'b0;
    n = 0;
    while (dmemresp_val !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) ok = 1'b0;
    rtyp = dmemresp_type; rdata = dmemresp_rdata;
    tick();
  endtask

  task automatic iread(input logic [31:0] a, output logic ok, output logic [31:0] data);
    int n;
    ok = 1'b1;
    imemresp_rdy = 1'b1;
    imemreq_val = 1'b1; imemreq_addr = a;
    n = 0;
    while (imemreq_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) ok = 1'b0;
    tick();
    imemreq_val = 1'b0;
    n = 0;
    while (imemresp_val !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) ok = 1'b0;
    data = imemresp_data;
    tick();
  endtask

  task automatic test_reset();
    logic ok, rt;
    logic [31:0] rd;
    int n;
    n_tests++; if (imemreq_rdy !== 1'b1 || dmemreq_rdy !== 1'b1) begin n_fail++;
      $display("FAIL rst_req_rdy got i=%b d=%b exp 1", imemreq_rdy, dmemreq_rdy); end
    n_tests++; if (imemresp_val !== 1'b0 || dmemresp_val !== 1'b0) begin n_fail++;
      $display("FAIL rst_resp_val got i=%b d=%b exp 0", imemresp_val, dmemresp_val); end
    n_tests++; if (imemresp_data !== 32'h0 || dmemresp_rdata !== 32'h0 || dmemresp_type !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp_data got %h %h %b exp 0", imemresp_data, dmemresp_rdata, dmemresp_type); end
    rst = 1'b0;
    tick();
    dreq(1'b1, 32'h0C, 32'hDEADBEEF, 4'hF, ok, rt, rd);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL preload_timeout got %b exp 1", ok); end
    imemresp_rdy = 1'b1; imemreq_val = 1'b1; imemreq_addr = 32'h0C;
    tick();
    imemreq_val = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      n_tests++; if (imemresp_val !== 1'b0) begin n_fail++;
        $display("FAIL lat_early k=%0d got %b exp 0", k, imemresp_val); end
      tick();
    end
    n_tests++; if (imemresp_val !== 1'b1 || imemresp_data !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL lat_resp got val=%b data=%h exp 1 deadbeef", imemresp_val, imemresp_data); end
    tick();
    n_tests++; if (imemresp_val !== 1'b0) begin n_fail++;
      $display("FAIL lat_after got %b exp 0", imemresp_val); end
    imemresp_rdy = 1'b0; imemreq_val = 1'b1;
    tick(); tick();
    imemreq_val = 1'b0;
    n = 0;
    while (imemresp_val !== 1'b1 && n < 20) begin tick(); n++; end
    n_tests++; if (imemresp_val !== 1'b1) begin n_fail++;
      $display("FAIL inflight_before_rst got %b exp 1", imemresp_val); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (imemresp_val !== 1'b0 || imemreq_rdy !== 1'b1 || imemresp_data !== 32'h0) begin
      n_fail++; $display("FAIL async_rst got val=%b rdy=%b data=%h exp 0 1 0",
                         imemresp_val, imemreq_rdy, imemresp_data); end
    @(negedge clk);
    rst = 1'b0;
    imemresp_rdy = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      n_tests++; if (imemresp_val !== 1'b0) begin n_fail++;
        $display("FAIL dropped_resp k=%0d got %b exp 0", k, imemresp_val); end
      tick();
    end
    iread(32'h0C, ok, rd);
    n_tests++; if (ok !== 1'b1 || rd !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL survive_rst got ok=%b data=%h exp 1 deadbeef", ok, rd); end
  endtask

  task automatic test_strobe_write();
    logic ok, rt;
    logic [31:0] rd;
    dreq(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, ok, rt, rd);
    dreq(1'b1, 32'h10, 32'h11223344, 4'b0101, ok, rt, rd);
    n_tests++; if (ok !== 1'b1 || rt !== 1'b1 || rd !== 32'h0) begin n_fail++;
      $display("FAIL write_ack got ok=%b type=%b rdata=%h exp 1 1 0", ok, rt, rd); end
    dreq(1'b0, 32'h10, 32'h0, 4'h0, ok, rt, rd);
    n_tests++; if (ok !== 1'b1 || rt !== 1'b0 || rd !== 32'hAA22CC44) begin n_fail++;
      $display("FAIL strobe_read got ok=%b type=%b rdata=%h exp 1 0 aa22cc44", ok, rt, rd); end
    dreq(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, ok, rt, rd);
    n_tests++; if (ok !== 1'b1 || rt !== 1'b1 || rd !== 32'h0) begin n_fail++;
      $display("FAIL noop_ack got ok=%b type=%b rdata=%h exp 1 1 0", ok, rt, rd); end
    dreq(1'b0, 32'h10, 32'h0, 4'h0, ok, rt, rd);
    n_tests++; if (rd !== 32'hAA22CC44) begin n_fail++;
      $display("FAIL noop_read got %h exp aa22cc44", rd); end
  endtask

  task automatic test_back_to_back();
    logic ok, rt, ev;
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) begin
      dreq(1'b1, 32'(i * 4), 32'(i * 16), 4'hF, ok, rt, rd);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_preload i=%0d got %b exp 1", i, ok); end
    end
    imemresp_rdy = 1'b1;
    for (int j = 0; j < 8 + LAT + 2; j++) begin
      imemreq_val = (j < 8); imemreq_addr = 32'(j * 4);
      if (j < 8) begin
        n_tests++; if (imemreq_rdy !== 1'b1) begin n_fail++;
          $display("FAIL b2b_rdy j=%0d got %b exp 1", j, imemreq_rdy); end
      end
      ev = (j >= LAT) && (j - LAT < 8);
      n_tests++; if (imemresp_val !== ev) begin n_fail++;
        $display("FAIL b2b_val j=%0d got %b exp %b", j, imemresp_val, ev); end
      if (ev) begin
        n_tests++; if (imemresp_data !== 32'((j - LAT) * 16)) begin n_fail++;
          $display("FAIL b2b_data j=%0d got %h exp %h", j, imemresp_data, 32'((j - LAT) * 16)); end
      end
      tick();
    end
    imemreq_val = 1'b0;
  endtask

  task automatic test_backpressure();
    int p, got;
    logic erdy;
    p = 0;
    dmemresp_rdy = 1'b0; imemresp_rdy = 1'b1;
    for (int j = 0; j < QD + LAT + 3; j++) begin
      dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'(p * 4);
      imemreq_val = (j == 0); imemreq_addr = 32'h14;
      erdy = (j < QD);
      n_tests++; if (dmemreq_rdy !== erdy) begin n_fail++;
        $display("FAIL bp_rdy j=%0d got %b exp %b", j, dmemreq_rdy, erdy); end
      if (j >= LAT) begin
        n_tests++; if (dmemresp_val !== 1'b1 || dmemresp_rdata !== 32'h0) begin n_fail++;
          $display("FAIL bp_hold j=%0d got val=%b data=%h exp 1 0", j, dmemresp_val, dmemresp_rdata); end
      end
      if (j == LAT) begin
        n_tests++; if (imemresp_val !== 1'b1 || imemresp_data !== 32'h50) begin n_fail++;
          $display("FAIL bp_imem got val=%b data=%h exp 1 50", imemresp_val, imemresp_data); end
      end
      if (dmemreq_rdy === 1'b1) p++;
      tick();
    end
    imemreq_val = 1'b0;
    dmemresp_rdy = 1'b1;
    tick();
    n_tests++; if (dmemreq_rdy !== 1'b1) begin n_fail++;
      $display("FAIL bp_reopen got %b exp 1", dmemreq_rdy); end
    got = 0;
    for (int j = 0; j < 20; j++) begin
      if (j == 1) dmemreq_val = 1'b0;
      if (dmemresp_val === 1'b1) begin
        got++;
        n_tests++; if (dmemresp_rdata !== 32'(got * 16)) begin n_fail++;
          $display("FAIL bp_order n=%0d got %h exp %h", got, dmemresp_rdata, 32'(got * 16)); end
      end
      tick();
    end
    n_tests++; if (got !== QD) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", got, QD); end
  endtask

  task automatic test_same_edge();
    logic ok, rt;
    logic [31:0] rd;
    dreq(1'b1, 32'h20, 32'h9, 4'hF, ok, rt, rd);
    imemresp_rdy = 1'b1; dmemresp_rdy = 1'b1;
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h20;
    dmemreq_wdata = 32'h5; dmemreq_strb = 4'hF;
    imemreq_val = 1'b1; imemreq_addr = 32'h20;
    n_tests++; if (dmemreq_rdy !== 1'b1 || imemreq_rdy !== 1'b1) begin n_fail++;
      $display("FAIL same_rdy got d=%b i=%b exp 1 1", dmemreq_rdy, imemreq_rdy); end
    tick();
    imemreq_val = 1'b0; dmemreq_type = 1'b0;
    tick();
    dmemreq_val = 1'b0;
    for (int j = 2; j <= LAT + 2; j++) begin
      if (j == LAT) begin
        n_tests++; if (imemresp_val !== 1'b1 || imemresp_data !== 32'h9) begin n_fail++;
          $display("FAIL same_imem_old got val=%b data=%h exp 1 9", imemresp_val, imemresp_data); end
        n_tests++; if (dmemresp_val !== 1'b1 || dmemresp_type !== 1'b1 || dmemresp_rdata !== 32'h0) begin
          n_fail++; $display("FAIL same_ack got val=%b type=%b data=%h exp 1 1 0",
                             dmemresp_val, dmemresp_type, dmemresp_rdata); end
      end
      if (j == LAT + 1) begin
        n_tests++; if (dmemresp_val !== 1'b1 || dmemresp_type !== 1'b0 || dmemresp_rdata !== 32'h5) begin
          n_fail++; $display("FAIL same_dmem_new got val=%b type=%b data=%h exp 1 0 5",
                             dmemresp_val, dmemresp_type, dmemresp_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_alias();
    logic ok, rt;
    logic [31:0] rd;
    dreq(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, ok, rt, rd);
    dreq(1'b0, 32'h0, 32'h0, 4'h0, ok, rt, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_100 got %h exp cafef00d", rd); end
    dreq(1'b0, 32'h103, 32'h0, 4'h0, ok, rt, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_103 got %h exp cafef00d", rd); end
    dreq(1'b1, 32'h1FC, 32'h0BADC0DE, 4'hF, ok, rt, rd);
    iread(32'hFC, ok, rd);
    n_tests++; if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL alias_top got %h exp 0badc0de", rd); end
  endtask

  task automatic test_random();
    exp_t iq[$];
    exp_t dq[$];
    exp_t e;
    logic [31:0] mm [DEPTH];
    logic ok, rt, act, erdy, ev;
    logic [31:0] rd;
    int unsigned idx;
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = $urandom;
      dreq(1'b1, 32'(i * 4), mm[i], 4'hF, ok, rt, rd);
    end
    for (int n = 0; n < NRAND + 40; n++) begin
      act = (n < NRAND);
      imemreq_val = act && ($urandom_range(0, 3) != 0);
      imemreq_addr = $urandom;
      imemresp_rdy = !act || ($urandom_range(0, 2) != 0);
      dmemreq_val = act && ($urandom_range(0, 3) != 0);
      dmemreq_type = 1'($urandom_range(0, 1));
      dmemreq_addr = $urandom; dmemreq_wdata = $urandom; dmemreq_strb = 4'($urandom);
      dmemresp_rdy = !act || ($urandom_range(0, 2) != 0);
      erdy = (iq.size() < QD);
      n_tests++; if (imemreq_rdy !== erdy) begin n_fail++;
        $display("FAIL rnd_irdy n=%0d got %b exp %b", n, imemreq_rdy, erdy); end
      ev = (iq.size() > 0) && (iq[0].cyc + LAT <= n);
      n_tests++; if (imemresp_val !== ev) begin n_fail++;
        $display("FAIL rnd_ival n=%0d got %b exp %b", n, imemresp_val, ev); end
      if (ev) begin
        n_tests++; if (imemresp_data !== iq[0].data) begin n_fail++;
          $display("FAIL rnd_idata n=%0d got %h exp %h", n, imemresp_data, iq[0].data); end
        if (imemresp_rdy) void'(iq.pop_front());
      end
      if (imemreq_val && erdy) begin
        e.data = mm[(imemreq_addr >> 2) % DEPTH]; e.typ = 1'b0; e.cyc = n;
        iq.push_back(e);
      end
      erdy = (dq.size() < QD);
      n_tests++; if (dmemreq_rdy !== erdy) begin n_fail++;
        $display("FAIL rnd_drdy n=%0d got %b exp %b", n, dmemreq_rdy, erdy); end
      ev = (dq.size() > 0) && (dq[0].cyc + LAT <= n);
      n_tests++; if (dmemresp_val !== ev) begin n_fail++;
        $display("FAIL rnd_dval n=%0d got %b exp %b", n, dmemresp_val, ev); end
      if (ev) begin
        n_tests++; if (dmemresp_rdata !== dq[0].data || dmemresp_type !== dq[0].typ) begin n_fail++;
          $display("FAIL rnd_ddata n=%0d got %b/%h exp %b/%h", n, dmemresp_type, dmemresp_rdata,
                   dq[0].typ, dq[0].data); end
        if (dmemresp_rdy) void'(dq.pop_front());
      end
      if (dmemreq_val && erdy) begin
        idx = (dmemreq_addr >> 2) % DEPTH;
        e.typ = dmemreq_type; e.cyc = n;
        e.data = dmemreq_type ? 32'h0 : mm[idx];
        if (dmemreq_type) mm[idx] = merge(mm[idx], dmemreq_wdata, dmemreq_strb);
        dq.push_back(e);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    imemreq_val = 1'b0; imemreq_addr = '0; imemresp_rdy = 1'b0;
    dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0;
    dmemreq_wdata = '0; dmemreq_strb = '0; dmemresp_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_strobe_write();
    test_back_to_back();
    test_backpressure();
    test_same_edge();
    test_alias();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
